// File: rtl/lane_fifo_bank.sv
// Bank of LANES independent FIFOs fed a row at a time and popped per lane to feed a systolic array.
// Optional sticky overflow/underflow flags are compiled in with LANE_FIFO_ERR_EN.
module lane_fifo_bank #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [LANES*WIDTH-1:0] wr_data,
   input  logic [LANES-1:0]       fifo_en,
   output logic [LANES*WIDTH-1:0] rd_data,
   output logic [LANES-1:0]       rd_valid,
   output logic                   full,
   output logic [LANES-1:0]       empty,
   output logic [1:0]             err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [LANES][DEPTH];
   logic [AW-1:0]    wr_ptr [LANES];
   logic [AW-1:0]    rd_ptr [LANES];
   logic [CW-1:0]    cnt    [LANES];

   logic             full_c;
   logic [LANES-1:0] empty_c;
   logic [LANES-1:0] pop;
   logic             wr_acc;

   logic [LANES*WIDTH-1:0] rd_data_p1;
   logic [LANES-1:0]       vld_p1;

   always_comb begin
      full_c  = 1'b0;
      empty_c = '0;
      for (int i = 0; i < LANES; i++) begin
         empty_c[i] = (cnt[i] == '0);
         if (cnt[i] == CW'(DEPTH)) full_c = 1'b1;
      end
   end

   // Full is the OR over lanes, so a pop on the fullest lane cannot admit a same-cycle write.
   assign wr_acc = wr_en & ~full_c;
   assign pop    = fifo_en & ~empty_c;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = 0; i < LANES; i++) begin
            mem[i][wr_ptr[i]] <= wr_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Stage p0 -> p1: pointer/count update and registered read with zero bubbles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LANES; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
         rd_data_p1 <= '0;
         vld_p1     <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_acc) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
            cnt[i] <= cnt[i] + CW'(wr_acc) - CW'(pop[i]);
            rd_data_p1[i*WIDTH +: WIDTH] <= pop[i] ? mem[i][rd_ptr[i]] : '0;
         end
         vld_p1 <= pop;
      end
   end

   assign rd_data  = rd_data_p1;
   assign rd_valid = vld_p1;
   assign full     = full_c;
   assign empty    = empty_c;

`ifdef LANE_FIFO_ERR_EN
   logic [1:0] err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 2'b00;
      end else begin
         if (wr_en && full_c)           err_q[0] <= 1'b1;
         if (|(fifo_en & empty_c))      err_q[1] <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 2'b00;
`endif

endmodule

// File: tb/tb_lane_fifo_bank.sv
// Bench for lane_fifo_bank: directed scenarios plus random traffic against a per-lane queue model.
module tb_lane_fifo_bank;

   localparam int WIDTH = 8;
   localparam int LANES = 4;
   localparam int DEPTH = 8;

   logic                   clk;
   logic                   reset;
   logic                   wr_en;
   logic [LANES*WIDTH-1:0] wr_data;
   logic [LANES-1:0]       fifo_en;
   logic [LANES*WIDTH-1:0] rd_data;
   logic [LANES-1:0]       rd_valid;
   logic                   full;
   logic [LANES-1:0]       empty;
   logic [1:0]             err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0]       q [LANES][$];
   logic                   e_ovf, e_unf;
   logic [LANES*WIDTH-1:0] exp_rd;
   logic [LANES-1:0]       exp_vld;

`ifdef LANE_FIFO_ERR_EN
   localparam logic [1:0] ERR_MASK = 2'b11;
`else
   localparam logic [1:0] ERR_MASK = 2'b00;
`endif

   lane_fifo_bank #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .fifo_en  (fifo_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      tests_run++;
      assert (obs === req) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   function automatic logic model_full();
      for (int i = 0; i < LANES; i++) if (q[i].size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [LANES-1:0] model_empty();
      logic [LANES-1:0] e;
      for (int i = 0; i < LANES; i++) e[i] = (q[i].size() == 0);
      return e;
   endfunction

   function automatic logic [LANES*WIDTH-1:0] row(input int k);
      logic [LANES*WIDTH-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'(k*16 + i);
      return r;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_rd_data"},  32'(rd_data),  32'(exp_rd));
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(exp_vld));
      chk({tag, "_full"},     32'(full),     32'(model_full()));
      chk({tag, "_empty"},    32'(empty),    32'(model_empty()));
      chk({tag, "_err"},      32'(err),      32'({e_unf, e_ovf} & ERR_MASK));
   endtask

   // Called right after a falling edge; applies inputs for one rising edge and checks after it.
   task automatic step(input string tag, input logic we, input logic [LANES*WIDTH-1:0] wd,
                       input logic [LANES-1:0] fe);
      logic             pre_full;
      logic [LANES-1:0] pre_empty;
      wr_en   = we;
      wr_data = wd;
      fifo_en = fe;
      pre_full  = model_full();
      pre_empty = model_empty();
      exp_rd  = '0;
      exp_vld = '0;
      for (int i = 0; i < LANES; i++) begin
         if (fe[i] && !pre_empty[i]) begin
            exp_rd[i*WIDTH +: WIDTH] = q[i].pop_front();
            exp_vld[i] = 1'b1;
         end
      end
      if (we) begin
         if (pre_full) e_ovf = 1'b1;
         else for (int i = 0; i < LANES; i++) q[i].push_back(wd[i*WIDTH +: WIDTH]);
      end
      if (|(fe & pre_empty)) e_unf = 1'b1;
      @(posedge clk);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < LANES; i++) q[i].delete();
      e_ovf   = 1'b0;
      e_unf   = 1'b0;
      exp_rd  = '0;
      exp_vld = '0;
   endtask

   task automatic do_reset(input string tag);
      wr_en   = 1'b0;
      fifo_en = '0;
      wr_data = '0;
      reset   = 1'b0;
      #1;
      clear_model();
      check_all(tag);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      fifo_en = '0;
      clear_model();
      #1;
      check_all("por");
      @(negedge clk);
      reset = 1'b1;

      // Four rows, then four full-width pops in order.
      for (int k = 1; k <= 4; k++) step("s1_wr", 1'b1, row(k), 4'b0000);
      for (int k = 1; k <= 4; k++) step("s1_pop", 1'b0, '0, 4'b1111);
      step("s1_idle", 1'b0, '0, 4'b0000);
      chk("s1_empty_all", 32'(empty), 32'hF);

      // Staggered enable ramp-in and ramp-out over eight rows.
      do_reset("s2_rst");
      for (int k = 0; k < 8; k++) step("s2_wr", 1'b1, row(k + 1), 4'b0000);
      step("s2_st0", 1'b0, '0, 4'b0001);
      chk("s2_lane0_only", 32'(rd_valid), 32'h1);
      step("s2_st1", 1'b0, '0, 4'b0011);
      step("s2_st2", 1'b0, '0, 4'b0111);
      for (int k = 0; k < 5; k++) step("s2_all", 1'b0, '0, 4'b1111);
      step("s2_out0", 1'b0, '0, 4'b1110);
      step("s2_out1", 1'b0, '0, 4'b1100);
      step("s2_out2", 1'b0, '0, 4'b1000);
      chk("s2_drained", 32'(empty), 32'hF);

      // Overflow: ninth row of 0xFF is dropped.
      do_reset("s3_rst");
      for (int k = 0; k < 8; k++) step("s3_wr", 1'b1, row(k + 1), 4'b0000);
      chk("s3_full", 32'(full), 32'h1);
      step("s3_drop", 1'b1, {LANES{8'hFF}}, 4'b0000);
      chk("s3_err", 32'(err), 32'(2'b01 & ERR_MASK));
      for (int k = 0; k < 8; k++) step("s3_pop", 1'b0, '0, 4'b1111);

      // Full bank with simultaneous write and pop: write rejected, full drops.
      do_reset("s4_rst");
      for (int k = 0; k < 8; k++) step("s4_wr", 1'b1, row(k + 2), 4'b0000);
      step("s4_wrpop", 1'b1, row(15), 4'b1111);
      chk("s4_not_full", 32'(full), 32'h0);
      for (int k = 0; k < 7; k++) step("s4_pop", 1'b0, '0, 4'b1111);

      // Twelve rows across the pointer wrap.
      do_reset("s5_rst");
      for (int k = 0; k < 6; k++) step("s5_wr", 1'b1, row(k + 1), 4'b0000);
      for (int k = 6; k < 12; k++) step("s5_wrpop", 1'b1, row(k + 1), 4'b1111);
      for (int k = 0; k < 6; k++) step("s5_pop", 1'b0, '0, 4'b1111);

      // Random traffic including full/empty corner hits.
      do_reset("s6_rst");
      for (int k = 0; k < 300; k++) begin
         step("rnd", 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      end

      // Reset asserted between edges with three rows buffered.
      do_reset("s7_rst");
      for (int k = 0; k < 3; k++) step("s7_wr", 1'b1, row(k + 4), 4'b0000);
      #2;
      reset = 1'b0;
      #1;
      clear_model();
      check_all("s7_async");
      @(negedge clk);
      reset = 1'b1;
      step("s7_after", 1'b0, '0, 4'b1111);

      wr_en   = 1'b0;
      fifo_en = '0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
